// File: rtl/act_vec_serializer.sv
// Accumulator-vector post-processor: optional ReLU, rounding shift and saturation per
// element, double-buffered, then streamed one element per handshake to the next layer.

module act_vec_serializer_lane #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 0,
    parameter int ROUND     = 1
) (
    input  logic signed [IN_WIDTH-1:0]  x,
    input  logic                        relu_en,
    output logic signed [OUT_WIDTH-1:0] y,
    output logic                        sat
);
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [IN_WIDTH:0] RND =
        (ROUND != 0 && SHIFT > 0) ? ({{IN_WIDTH{1'b0}}, 1'b1} << RND_SH) : '0;
    localparam logic signed [IN_WIDTH:0] MAX_V =
        {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] MIN_V =
        {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [IN_WIDTH:0] r;
    logic signed [IN_WIDTH:0] s;

    // One extra bit of headroom so the rounding add cannot wrap.
    always_comb begin
        r   = (relu_en && x[IN_WIDTH-1]) ? '0 : {x[IN_WIDTH-1], x};
        s   = (r + RND) >>> SHIFT;
        y   = s[OUT_WIDTH-1:0];
        sat = 1'b0;
        if (s > MAX_V) begin
            y   = MAX_V[OUT_WIDTH-1:0];
            sat = 1'b1;
        end else if (s < MIN_V) begin
            y   = MIN_V[OUT_WIDTH-1:0];
            sat = 1'b1;
        end
    end
endmodule

module act_vec_serializer #(
    parameter int NUM_ELEMS = 16,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 0,
    parameter int ROUND     = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [IN_WIDTH-1:0]       in_vec [NUM_ELEMS-1:0],
    input  logic                             relu_en,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [OUT_WIDTH-1:0]      out_data,
    output logic [$clog2(NUM_ELEMS)-1:0]     out_index,
    output logic                             out_last,
    output logic [15:0]                      sat_count
);
    localparam int IDX_W = $clog2(NUM_ELEMS);
    localparam int CNT_W = $clog2(NUM_ELEMS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                      state_q, state_d;
    logic signed [OUT_WIDTH-1:0] lane_y [NUM_ELEMS-1:0];
    logic [NUM_ELEMS-1:0]        lane_sat;
    logic signed [OUT_WIDTH-1:0] mem_q [2][NUM_ELEMS];
    logic [1:0]                  full_q;
    logic                        wr_ptr_q, rd_ptr_q;
    logic [IDX_W-1:0]            idx_q;
    logic                        in_fire, out_fire, last_fire;
    logic [CNT_W-1:0]            sat_pop;
    logic [16:0]                 sat_sum;

    for (genvar g = 0; g < NUM_ELEMS; g++) begin : g_lane
        act_vec_serializer_lane #(
            .IN_WIDTH (IN_WIDTH),
            .OUT_WIDTH(OUT_WIDTH),
            .SHIFT    (SHIFT),
            .ROUND    (ROUND)
        ) u_lane (
            .x      (in_vec[g]),
            .relu_en(relu_en),
            .y      (lane_y[g]),
            .sat    (lane_sat[g])
        );
    end

    assign in_ready  = !rst && !(full_q[0] && full_q[1]);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state_q == STREAM);
    assign out_fire  = out_valid && out_ready;
    assign last_fire = out_fire && (idx_q == LAST_IDX);

    // A capture landing this cycle counts as "full" so the stream starts (or
    // continues) without a bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:
                if (full_q[rd_ptr_q] || (in_fire && wr_ptr_q == rd_ptr_q))
                    state_d = STREAM;
            STREAM:
                if (last_fire && !(full_q[!rd_ptr_q] || (in_fire && wr_ptr_q != rd_ptr_q)))
                    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sat_pop = '0;
        for (int i = 0; i < NUM_ELEMS; i++)
            sat_pop = sat_pop + CNT_W'(lane_sat[i]);
        sat_sum = {1'b0, sat_count} + 17'(sat_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            full_q    <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            idx_q     <= '0;
            sat_count <= '0;
        end else begin
            state_q <= state_d;
            if (in_fire) begin
                full_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q         <= !wr_ptr_q;
                sat_count        <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
            end
            if (last_fire) begin
                full_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q         <= !rd_ptr_q;
                idx_q            <= '0;
            end else if (out_fire) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire)
            for (int i = 0; i < NUM_ELEMS; i++)
                mem_q[wr_ptr_q][i] <= lane_y[i];
    end

    // Outputs are zeroed while idle so stale buffer contents never show.
    always_comb begin
        out_data  = '0;
        if (out_valid)
            out_data = mem_q[rd_ptr_q][idx_q];
        out_index = idx_q;
        out_last  = out_valid && (idx_q == LAST_IDX);
    end
endmodule

// File: tb/tb_act_vec_serializer.sv
// Bench for act_vec_serializer: two instances (SHIFT=0 and SHIFT=8) share stimulus and
// are checked against a queue-based reference model of the element stream.

module tb_act_vec_serializer;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic relu_en = 1'b0;
    logic out_ready = 1'b0;
    logic signed [31:0] in_vec [N-1:0];
    logic ir0, ir8, ov0, ov8, olast0, olast8;
    logic signed [15:0] od0, od8;
    logic [3:0] oidx0, oidx8;
    logic [15:0] sc0, sc8;

    always #5 clk = ~clk;

    act_vec_serializer #(.NUM_ELEMS(N), .IN_WIDTH(32), .OUT_WIDTH(16), .SHIFT(0), .ROUND(1)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_vec(in_vec),
        .relu_en(relu_en), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .out_index(oidx0), .out_last(olast0), .sat_count(sc0));

    act_vec_serializer #(.NUM_ELEMS(N), .IN_WIDTH(32), .OUT_WIDTH(16), .SHIFT(8), .ROUND(1)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8), .in_vec(in_vec),
        .relu_en(relu_en), .out_valid(ov8), .out_ready(out_ready), .out_data(od8),
        .out_index(oidx8), .out_last(olast8), .sat_count(sc8));

    typedef struct {int d0; int d8; int idx; bit last;} elem_t;

    elem_t exp_q[$];
    elem_t s_exp;
    int total = 0;
    int bad = 0;
    int sat0_m = 0;
    int sat8_m = 0;
    bit s_fire, s_have, s_cap;
    logic s_valid, s_valid8, s_last, s_last8, s_in_ready, s_in_ready8;
    logic signed [31:0] s_d0, s_d8;
    logic [31:0] s_idx, s_idx8, s_sat0, s_sat8;
    int s_sat0_e, s_sat8_e;

    // Element value from the arithmetic definition: ReLU, round-half-up divide by 2^sh
    // (floor division), then clamp to the 16-bit signed range.
    function automatic void ref_elem(input longint x, input bit relu, input int sh,
                                     output int val, output bit sat);
        longint r, s, d;
        r = (relu && x < 0) ? 0 : x;
        s = r;
        if (sh > 0) begin
            d = longint'(1) << sh;
            s = r + d / 2;
            s = (s >= 0) ? s / d : -((-s + d - 1) / d);
        end
        sat = 1'b1;
        if (s > 32767) val = 32767;
        else if (s < -32768) val = -32768;
        else begin
            val = int'(s);
            sat = 1'b0;
        end
    endfunction

    // One clock: snapshot outputs at the falling edge, advance the model, then return
    // just after the next rising edge so the caller can drive the following cycle.
    task automatic tick();
        elem_t e;
        int n0, n8, v;
        bit st;
        @(negedge clk);
        s_valid = ov0; s_valid8 = ov8; s_d0 = od0; s_d8 = od8;
        s_idx = oidx0; s_idx8 = oidx8; s_last = olast0; s_last8 = olast8;
        s_in_ready = ir0; s_in_ready8 = ir8; s_sat0 = sc0; s_sat8 = sc8;
        s_sat0_e = sat0_m; s_sat8_e = sat8_m;
        s_fire = ov0 && out_ready && !rst;
        s_have = 1'b0;
        if (s_fire && exp_q.size() > 0) begin
            s_exp = exp_q.pop_front();
            s_have = 1'b1;
        end
        s_cap = in_valid && ir0 && !rst;
        if (rst) begin
            exp_q.delete();
            sat0_m = 0;
            sat8_m = 0;
        end else if (s_cap) begin
            n0 = 0; n8 = 0;
            for (int i = 0; i < N; i++) begin
                ref_elem(longint'(in_vec[i]), relu_en, 0, v, st);
                e.d0 = v; n0 += int'(st);
                ref_elem(longint'(in_vec[i]), relu_en, 8, v, st);
                e.d8 = v; n8 += int'(st);
                e.idx = i;
                e.last = (i == N - 1);
                exp_q.push_back(e);
            end
            sat0_m = (sat0_m + n0 > 65535) ? 65535 : sat0_m + n0;
            sat8_m = (sat8_m + n8 > 65535) ? 65535 : sat8_m + n8;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec_random();
        int v;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
                0: v = int'($urandom);
                1: v = int'($urandom_range(0, 600)) - 300;
                2: v = int'($urandom_range(0, 200000)) - 100000;
                default: v = int'($urandom_range(0, 1 << 26)) - (1 << 25);
            endcase
            in_vec[i] = v;
        end
        relu_en = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) in_vec[i] = '0;
        tick();
        tick();
        total++;
        if (s_in_ready !== 1'b0 || s_in_ready8 !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_ready got %b/%b want 0", s_in_ready, s_in_ready8);
        end
        rst = 1'b0;
        tick();
        total++;
        if (s_valid !== 1'b0 || s_d0 !== 0 || s_idx !== 0 || s_last !== 1'b0 || s_valid8 !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got valid=%b data=%0d idx=%0d last=%b want 0 0 0 0", s_valid, s_d0, s_idx, s_last);
        end
        total++;
        if (s_sat0 !== 0 || s_sat8 !== 0 || s_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_sat got sat=%0d/%0d in_ready=%b want 0/0 1", s_sat0, s_sat8, s_in_ready);
        end
    endtask

    task automatic test_single();
        relu_en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_vec[i] = i - 8;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if (!s_cap) begin bad++; $display("FAIL single_capture got 0 want 1"); end
        for (int k = 0; k < N; k++) begin
            tick();
            total++;
            if (!s_fire) begin bad++; $display("FAIL single_latency elem %0d got valid=%b want 1", k, s_valid); end
            if (s_fire) begin
                total++;
                if (!s_have || s_d0 !== s_exp.d0 || s_d8 !== s_exp.d8 || s_idx !== s_exp.idx || s_idx8 !== s_exp.idx ||
                    s_last !== s_exp.last || s_last8 !== s_exp.last || !s_valid8) begin
                    bad++;
                    $display("FAIL single_elem got d0=%0d d8=%0d idx=%0d last=%b want d0=%0d d8=%0d idx=%0d last=%b",
                             s_d0, s_d8, s_idx, s_last, s_exp.d0, s_exp.d8, s_exp.idx, s_exp.last);
                end
            end
            total++;
            if (s_d0 !== ((k < 9) ? 0 : k - 8)) begin
                bad++;
                $display("FAIL single_value elem %0d got %0d want %0d", k, s_d0, (k < 9) ? 0 : k - 8);
            end
        end
        tick();
        total++;
        if (s_valid !== 1'b0 || s_sat0 !== 0 || s_sat8 !== 0) begin
            bad++;
            $display("FAIL single_end got valid=%b sat=%0d/%0d want 0 0/0", s_valid, s_sat0, s_sat8);
        end
    endtask

    task automatic test_saturation();
        int want8 [5];
        want8 = '{32767, -32768, 2, -1, 1};
        relu_en = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_vec[i] = '0;
        in_vec[0] = 32'h7FFF_FFFF; in_vec[1] = 32'h8000_0000;
        in_vec[2] = 384; in_vec[3] = -384; in_vec[4] = 383;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            tick();
            total++;
            if (!s_fire || !s_have || s_d0 !== s_exp.d0 || s_d8 !== s_exp.d8 || s_idx !== s_exp.idx || s_last !== s_exp.last) begin
                bad++;
                $display("FAIL sat_elem got fire=%b d0=%0d d8=%0d idx=%0d want d0=%0d d8=%0d idx=%0d",
                         s_fire, s_d0, s_d8, s_idx, s_exp.d0, s_exp.d8, s_exp.idx);
            end
            total++;
            if (s_d8 !== ((k < 5) ? want8[k] : 0)) begin
                bad++;
                $display("FAIL sat_value elem %0d got %0d want %0d", k, s_d8, (k < 5) ? want8[k] : 0);
            end
        end
        tick();
        total++;
        if (s_sat0 !== 2 || s_sat8 !== 2 || s_sat0 !== s_sat0_e || s_sat8 !== s_sat8_e) begin
            bad++;
            $display("FAIL sat_count got %0d/%0d want 2/2", s_sat0, s_sat8);
        end
    endtask

    task automatic test_backpressure();
        bit pat [4];
        int got;
        bit p_stall;
        logic signed [31:0] p_d0, p_d8;
        logic [31:0] p_idx;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        set_vec_random();
        out_ready = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        got = 0; p_stall = 1'b0; p_d0 = '0; p_d8 = '0; p_idx = '0;
        for (int c = 0; c < 100 && got < N; c++) begin
            out_ready = pat[c % 4];
            tick();
            if (p_stall) begin
                total++;
                if (s_valid !== 1'b1 || s_d0 !== p_d0 || s_d8 !== p_d8 || s_idx !== p_idx) begin
                    bad++;
                    $display("FAIL bp_hold got valid=%b d0=%0d idx=%0d want 1 %0d %0d", s_valid, s_d0, s_idx, p_d0, p_idx);
                end
            end
            if (s_fire) begin
                got++;
                total++;
                if (!s_have || s_d0 !== s_exp.d0 || s_d8 !== s_exp.d8 || s_idx !== s_exp.idx || s_last !== s_exp.last) begin
                    bad++;
                    $display("FAIL bp_elem got d0=%0d d8=%0d idx=%0d last=%b want d0=%0d d8=%0d idx=%0d last=%b",
                             s_d0, s_d8, s_idx, s_last, s_exp.d0, s_exp.d8, s_exp.idx, s_exp.last);
                end
            end
            p_stall = s_valid && !s_fire;
            p_d0 = s_d0; p_d8 = s_d8; p_idx = s_idx;
        end
        total++;
        if (got != N) begin bad++; $display("FAIL bp_count got %0d want %0d", got, N); end
    endtask

    task automatic test_pingpong();
        out_ready = 1'b0;
        set_vec_random();
        in_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            total++;
            if (s_in_ready !== (t < 2) || s_in_ready8 !== (t < 2)) begin
                bad++;
                $display("FAIL pp_in_ready cycle %0d got %b want %b", t, s_in_ready, t < 2);
            end
            if (s_cap) set_vec_random();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3 * N; k++) begin
            tick();
            if (s_cap) in_valid = 1'b0;
            total++;
            if (!s_fire || !s_have || s_d0 !== s_exp.d0 || s_d8 !== s_exp.d8 || s_idx !== s_exp.idx || s_last !== s_exp.last) begin
                bad++;
                $display("FAIL pp_elem %0d got fire=%b d0=%0d idx=%0d last=%b want d0=%0d idx=%0d last=%b",
                         k, s_fire, s_d0, s_idx, s_last, s_exp.d0, s_exp.idx, s_exp.last);
            end
            if (k == N - 1 || k == N) begin
                total++;
                if (s_in_ready !== (k == N)) begin
                    bad++;
                    $display("FAIL pp_ready_return cycle %0d got %b want %b", k, s_in_ready, k == N);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (s_valid !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL pp_drain got valid=%b left=%0d want 0 0", s_valid, exp_q.size());
        end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b1;
        set_vec_random();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        set_vec_random();
        for (int k = 0; k < 2 * N; k++) begin
            if (k == N - 1) in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            total++;
            if (!s_fire || !s_have || s_d0 !== s_exp.d0 || s_d8 !== s_exp.d8 || s_idx !== s_exp.idx || s_last !== s_exp.last) begin
                bad++;
                $display("FAIL simul_elem %0d got fire=%b d0=%0d idx=%0d last=%b want d0=%0d idx=%0d last=%b",
                         k, s_fire, s_d0, s_idx, s_last, s_exp.d0, s_exp.idx, s_exp.last);
            end
            if (k == N - 1) begin
                total++;
                if (s_last !== 1'b1 || s_in_ready !== 1'b1 || !s_cap) begin
                    bad++;
                    $display("FAIL simul_capture got last=%b in_ready=%b want 1 1", s_last, s_in_ready);
                end
            end
        end
        tick();
        total++;
        if (s_valid !== 1'b0) begin bad++; $display("FAIL simul_idle got valid=%b want 0", s_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        set_vec_random();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            total++;
            if (!s_fire || !s_have || s_d0 !== s_exp.d0 || s_d8 !== s_exp.d8 || s_idx !== s_exp.idx) begin
                bad++;
                $display("FAIL rstmid_pre got fire=%b d0=%0d idx=%0d want d0=%0d idx=%0d", s_fire, s_d0, s_idx, s_exp.d0, s_exp.idx);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (s_valid !== 1'b0 || s_d0 !== 0 || s_d8 !== 0 || s_idx !== 0 || s_last !== 1'b0 ||
                s_sat0 !== 0 || s_sat8 !== 0 || s_in_ready !== 1'b1) begin
                bad++;
                $display("FAIL rstmid_state got valid=%b data=%0d idx=%0d last=%b sat=%0d want 0 0 0 0 0",
                         s_valid, s_d0, s_idx, s_last, s_sat0);
            end
        end
        set_vec_random();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            tick();
            total++;
            if (!s_fire || !s_have || s_d0 !== s_exp.d0 || s_d8 !== s_exp.d8 || s_idx !== k || s_last !== (k == N - 1)) begin
                bad++;
                $display("FAIL rstmid_post %0d got fire=%b d0=%0d idx=%0d want d0=%0d idx=%0d", k, s_fire, s_d0, s_idx, s_exp.d0, k);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit p_stall;
        logic signed [31:0] p_d0;
        logic [31:0] p_idx;
        p_stall = 1'b0; p_d0 = '0; p_idx = '0;
        set_vec_random();
        for (int c = 0; c < 600; c++) begin
            if (c < 500) in_valid = ($urandom_range(0, 2) != 0);
            else in_valid = 1'b0;
            out_ready = (c >= 500) || ($urandom_range(0, 3) != 0);
            tick();
            if (s_cap) set_vec_random();
            total++;
            if (s_sat0 !== s_sat0_e || s_sat8 !== s_sat8_e) begin
                bad++;
                $display("FAIL b2b_sat got %0d/%0d want %0d/%0d", s_sat0, s_sat8, s_sat0_e, s_sat8_e);
            end
            if (p_stall) begin
                total++;
                if (s_valid !== 1'b1 || s_d0 !== p_d0 || s_idx !== p_idx) begin
                    bad++;
                    $display("FAIL b2b_hold got valid=%b d0=%0d idx=%0d want 1 %0d %0d", s_valid, s_d0, s_idx, p_d0, p_idx);
                end
            end
            if (s_fire) begin
                total++;
                if (!s_have || s_d0 !== s_exp.d0 || s_d8 !== s_exp.d8 || s_idx !== s_exp.idx || s_last !== s_exp.last) begin
                    bad++;
                    $display("FAIL b2b_elem got d0=%0d d8=%0d idx=%0d last=%b want d0=%0d d8=%0d idx=%0d last=%b",
                             s_d0, s_d8, s_idx, s_last, s_exp.d0, s_exp.d8, s_exp.idx, s_exp.last);
                end
            end
            p_stall = s_valid && !s_fire;
            p_d0 = s_d0; p_idx = s_idx;
        end
        total++;
        if (exp_q.size() != 0 || s_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain got left=%0d valid=%b want 0 0", exp_q.size(), s_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_backpressure();
        test_pingpong();
        test_simultaneous();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
